mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipelined CPU's fetch stage (F, read-only)
//  and its memory stage (M, read/write). Sequences each access over a fixed-latency memory and
//  returns read data with a one-cycle ack. Drives stallcF/stallcM into the hazard unit, which
//  freezes the pipeline while either requester waits. Sits between the CPU core and memory.
// PARAMETERS
//  AW       32  address width (byte address, passed through unmodified)
//  DW       32  data width
//  LATENCY  2   memory cycles per access, >=1; mem_rdata valid in last ACCESS cycle
//  CW       16  width of conflict_cnt
// PORTS
//  mclk          in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  reqF          in   1   fetch request; held with addrF until ackF seen
//  addrF         in   AW  fetch address
//  rdataF        out  DW  fetch read data, registered, valid while ackF=1, held after
//  ackF          out  1   one-cycle completion pulse for fetch
//  reqM          in   1   data request; held with weM/addrM/wdataM until ackM seen
//  weM           in   1   1=write, 0=read
//  addrM         in   AW  data address
//  wdataM        in   DW  write data
//  rdataM        out  DW  data read data, registered, valid while ackM=1, held after
//  ackM          out  1   one-cycle completion pulse for data access
//  stallcF       out  1   reqF & ~ackF (combinational)
//  stallcM       out  1   reqM & ~ackM (combinational)
//  mem_en        out  1   memory access enable, registered
//  mem_we        out  1   memory write enable, registered, only with mem_en
//  mem_addr      out  AW  memory address, registered, stable during ACCESS
//  mem_wdata     out  DW  memory write data, registered, stable during ACCESS
//  mem_rdata     in   DW  memory read data
//  conflict_cnt  out  CW  saturating count of IDLE cycles where both ports eligible
// BEHAVIOUR
//  Reset: state=IDLE; ackF, ackM, mem_en, mem_we=0; mem_addr, mem_wdata, rdataF, rdataM,
//   conflict_cnt, cnt=0; grant=none. Reset mid-access aborts it: no ack, no retry.
//  FSM IDLE -> ACCESS -> IDLE. Down-counter cnt: $clog2(LATENCY+1) bits.
//  IDLE: port X eligible iff reqX=1 and ackX=0 (ack cycle masks finishing requester).
//   M eligible -> grant M; else F eligible -> grant F; else stay.
//   On grant: latch addr (+we, wdata for M; we=0 for F), mem_en<=1, cnt<=LATENCY-1, ->ACCESS.
//   Both eligible -> conflict_cnt+1, holds at all-ones.
//  ACCESS: mem_en/mem_we/mem_addr/mem_wdata held; cnt decrements.
//   cnt==0: ack of granted port<=1; on read, its rdata<=mem_rdata; mem_en, mem_we<=0; ->IDLE.
//   Writes leave rdata unchanged. New reqs ignored in ACCESS.
//  Ack is 1 cycle, always deasserted next cycle. Request at cycle t in IDLE: mem_en in
//   t+1..t+LATENCY, ack in t+LATENCY+1. Issue rate: 1 access per LATENCY+1 cycles.
//  Fairness: during ackM cycle, M is masked and waiting F is granted immediately. M can
//   therefore not starve F across back-to-back M accesses.
//  Requester's reqX dropping before ack: unspecified. Arbiter completes grant and pulses ack.
//  Inputs sampled only at grant. Later changes to addrX/wdataM during ACCESS have no effect.
// TESTING (LATENCY=2 unless stated; memory model returns addr^32'hA5A5A5A5)
//  reqF=1 addrF=0x40 at cycle 0 -> mem_en 1-2, mem_addr=0x40, ackF=1 and
//   rdataF=0xA5A5A5E5 in cycle 3, stallcF=1 cycles 0-2, 0 in 3.
//  reqF & reqM(read 0x100) at cycle 0 -> M granted first, ackM cycle 3. F granted cycle 3,
//   ackF cycle 6. conflict_cnt=1.
//  reqM weM=1 addrM=0x8 wdataM=0xDEADBEEF -> mem_we=1 cycles 1-2, mem_wdata=0xDEADBEEF,
//   ackM cycle 3, rdataM unchanged.
//  Back-to-back M reads with reqF held -> grant order M, F, M; F not starved.
//  reset pulsed cycle 2 of F access -> all outputs 0 next edge, no ackF. reqF still high ->
//   regranted after reset release.
//  CW=4, 20 simultaneous-request grants -> conflict_cnt saturates at 4'hF. LATENCY=1 ->
//   ack at t+2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Purpose : arbitrates one single-port fixed-latency memory between the CPU fetch (F) and memory (M) stages.
// Latency : request seen in IDLE at cycle t -> mem_en t+1..t+LATENCY, one-cycle ack at t+LATENCY+1.
// Backpressure: a requester holds reqX until its ack; stallcF/stallcM freeze the pipeline while waiting.
//
// Ports:
//   mclk, reset          clock, asynchronous active-high reset
//   reqF, addrF          fetch read request (held until ackF)
//   rdataF, ackF         fetch read data (registered, held) and completion pulse
//   reqM, weM, addrM,    data-stage request, 1=write 0=read, held until ackM
//   wdataM
//   rdataM, ackM         data-stage read data (registered, held) and completion pulse
//   stallcF, stallcM     reqX & ~ackX, combinational, to the hazard unit
//   mem_en, mem_we,      registered memory controls, stable for the whole access
//   mem_addr, mem_wdata
//   mem_rdata            memory read data, valid in the last access cycle
//   conflict_cnt         saturating count of IDLE cycles where both ports were eligible
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 2,
    parameter int CW      = 16
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          reqF,
    input  logic [AW-1:0] addrF,
    output logic [DW-1:0] rdataF,
    output logic          ackF,
    input  logic          reqM,
    input  logic          weM,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] wdataM,
    output logic [DW-1:0] rdataM,
    output logic          ackM,
    output logic          stallcF,
    output logic          stallcM,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    localparam int CNTW = $clog2(LATENCY + 1);
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_F    = 2'd1,
        GNT_M    = 2'd2
    } grant_t;

    state_t          state, state_nxt;
    grant_t          grant, grant_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic            ackF_nxt, ackM_nxt;
    logic [DW-1:0]   rdataF_nxt, rdataM_nxt;
    logic            mem_en_nxt, mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt;
    logic [CW-1:0]   conflict_nxt;
    logic            elig_f, elig_m;

    // A requester still holds req during its own ack cycle; masking with ack
    // keeps the finished request from being granted a second time and lets the
    // other port win that cycle, so back-to-back M traffic cannot starve F.
    assign elig_f = reqF & ~ackF;
    assign elig_m = reqM & ~ackM;

    assign stallcF = reqF & ~ackF;
    assign stallcM = reqM & ~ackM;

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        cnt_nxt       = cnt;
        ackF_nxt      = 1'b0;
        ackM_nxt      = 1'b0;
        rdataF_nxt    = rdataF;
        rdataM_nxt    = rdataM;
        mem_en_nxt    = mem_en;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        conflict_nxt  = conflict_cnt;

        case (state)
            IDLE: begin
                if (elig_f && elig_m && (conflict_cnt != {CW{1'b1}})) begin
                    conflict_nxt = conflict_cnt + CW'(1);
                end
                // M has priority; its request fields are captured only here.
                if (elig_m) begin
                    grant_nxt     = GNT_M;
                    state_nxt     = ACCESS;
                    cnt_nxt       = CNT_LOAD;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = weM;
                    mem_addr_nxt  = addrM;
                    mem_wdata_nxt = wdataM;
                end else if (elig_f) begin
                    grant_nxt    = GNT_F;
                    state_nxt    = ACCESS;
                    cnt_nxt      = CNT_LOAD;
                    mem_en_nxt   = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = addrF;
                end
            end
            ACCESS: begin
                // cnt==0 marks the last access cycle, where mem_rdata is valid.
                if (cnt == '0) begin
                    state_nxt  = IDLE;
                    grant_nxt  = GNT_NONE;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    if (grant == GNT_M) begin
                        ackM_nxt = 1'b1;
                        if (!mem_we) begin
                            rdataM_nxt = mem_rdata;
                        end
                    end else if (grant == GNT_F) begin
                        ackF_nxt   = 1'b1;
                        rdataF_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset during an access simply abandons it; a requester still asserting
    // req is granted afresh once reset releases.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= GNT_NONE;
            cnt          <= '0;
            ackF         <= 1'b0;
            ackM         <= 1'b0;
            rdataF       <= '0;
            rdataM       <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            cnt          <= cnt_nxt;
            ackF         <= ackF_nxt;
            ackM         <= ackM_nxt;
            rdataF       <= rdataF_nxt;
            rdataM       <= rdataM_nxt;
            mem_en       <= mem_en_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            conflict_cnt <= conflict_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : bench for mem_port_arbiter; two instances (LATENCY=2/CW=16 and LATENCY=1/CW=4) share stimulus.
// Latency : outputs compared mid-cycle against a cycle-scheduled reference model.
// Backpressure: bench requesters hold requests until the LATENCY=2 instance acknowledges them.
module tb_mem_port_arbiter;

    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic        reqF = 1'b0;
    logic        reqM = 1'b0;
    logic        weM = 1'b0;
    logic [31:0] addrF = '0;
    logic [31:0] addrM = '0;
    logic [31:0] wdataM = '0;

    logic [31:0] rdataF_d [2];
    logic [31:0] rdataM_d [2];
    logic [31:0] mem_addr_d [2];
    logic [31:0] mem_wdata_d [2];
    logic [31:0] mem_rdata_d [2];
    logic        ackF_d [2];
    logic        ackM_d [2];
    logic        stallcF_d [2];
    logic        stallcM_d [2];
    logic        mem_en_d [2];
    logic        mem_we_d [2];
    logic [15:0] conf0;
    logic [3:0]  conf1;

    always #5 mclk = ~mclk;

    // Memory returns address XOR constant in the last access cycle.
    assign mem_rdata_d[0] = mem_addr_d[0] ^ K;
    assign mem_rdata_d[1] = mem_addr_d[1] ^ K;

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(2), .CW(16)) dut0 (
        .mclk(mclk), .reset(reset),
        .reqF(reqF), .addrF(addrF), .rdataF(rdataF_d[0]), .ackF(ackF_d[0]),
        .reqM(reqM), .weM(weM), .addrM(addrM), .wdataM(wdataM),
        .rdataM(rdataM_d[0]), .ackM(ackM_d[0]),
        .stallcF(stallcF_d[0]), .stallcM(stallcM_d[0]),
        .mem_en(mem_en_d[0]), .mem_we(mem_we_d[0]), .mem_addr(mem_addr_d[0]),
        .mem_wdata(mem_wdata_d[0]), .mem_rdata(mem_rdata_d[0]),
        .conflict_cnt(conf0)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1), .CW(4)) dut1 (
        .mclk(mclk), .reset(reset),
        .reqF(reqF), .addrF(addrF), .rdataF(rdataF_d[1]), .ackF(ackF_d[1]),
        .reqM(reqM), .weM(weM), .addrM(addrM), .wdataM(wdataM),
        .rdataM(rdataM_d[1]), .ackM(ackM_d[1]),
        .stallcF(stallcF_d[1]), .stallcM(stallcM_d[1]),
        .mem_en(mem_en_d[1]), .mem_we(mem_we_d[1]), .mem_addr(mem_addr_d[1]),
        .mem_wdata(mem_wdata_d[1]), .mem_rdata(mem_rdata_d[1]),
        .conflict_cnt(conf1)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", nm, i, cyc, act, exp);
    endtask

    // Reference model: each access is a scheduled interval. A grant made at
    // cycle g occupies the memory for cycles g+1..g+L and acks at g+L+1; the
    // arbiter is free to grant again from the ack cycle onward.
    int          L    [2] = '{2, 1};
    int          CMAX [2] = '{65535, 15};
    bit          gv   [2];
    bit          gm   [2];
    bit          gwe  [2];
    int          gstart [2];
    logic [31:0] gaddr [2];
    logic [31:0] gwd   [2];
    logic [31:0] erF   [2];
    logic [31:0] erM   [2];
    int          econf [2];

    always @(negedge mclk) begin
        bit in_acc, ack_now, ackf_e, ackm_e, idle, elf, elm;
        int conf_act;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            conf_act = (i == 0) ? int'(conf0) : int'(conf1);
            if (reset) begin
                gv[i] = 1'b0; erF[i] = '0; erM[i] = '0; econf[i] = 0;
                chk("rst_ackF", i, ackF_d[i], 0);
                chk("rst_ackM", i, ackM_d[i], 0);
                chk("rst_mem_en", i, mem_en_d[i], 0);
                chk("rst_mem_we", i, mem_we_d[i], 0);
                chk("rst_rdataF", i, rdataF_d[i], 0);
                chk("rst_conflict", i, conf_act, 0);
            end else begin
                in_acc  = gv[i] && (cyc > gstart[i]) && (cyc <= gstart[i] + L[i]);
                ack_now = gv[i] && (cyc == gstart[i] + L[i] + 1);
                ackf_e  = ack_now && !gm[i];
                ackm_e  = ack_now && gm[i];
                if (ack_now && !gwe[i]) begin
                    if (gm[i]) erM[i] = gaddr[i] ^ K;
                    else       erF[i] = gaddr[i] ^ K;
                end
                chk("ackF", i, ackF_d[i], ackf_e);
                chk("ackM", i, ackM_d[i], ackm_e);
                chk("rdataF", i, rdataF_d[i], erF[i]);
                chk("rdataM", i, rdataM_d[i], erM[i]);
                chk("mem_en", i, mem_en_d[i], in_acc);
                chk("mem_we", i, mem_we_d[i], in_acc && gwe[i]);
                if (in_acc) chk("mem_addr", i, mem_addr_d[i], gaddr[i]);
                if (in_acc && gwe[i]) chk("mem_wdata", i, mem_wdata_d[i], gwd[i]);
                chk("stallcF", i, stallcF_d[i], reqF && !ackf_e);
                chk("stallcM", i, stallcM_d[i], reqM && !ackm_e);
                chk("conflict", i, conf_act, econf[i]);

                idle = !gv[i] || (cyc >= gstart[i] + L[i] + 1);
                elf  = reqF && !ackf_e;
                elm  = reqM && !ackm_e;
                if (idle) begin
                    if (elf && elm && econf[i] < CMAX[i]) econf[i]++;
                    if (elm || elf) begin
                        gv[i]     = 1'b1;
                        gstart[i] = cyc;
                        gm[i]     = elm;
                        gwe[i]    = elm ? weM : 1'b0;
                        gaddr[i]  = elm ? addrM : addrF;
                        gwd[i]    = wdataM;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge mclk);
        #1;
    endtask

    task automatic mid();
        @(negedge mclk);
        #1;
    endtask

    task automatic drive_rand();
        if (ackF_d[0]) begin
            reqF  = 1'($urandom % 2);
            addrF = $urandom;
        end else if (!reqF) begin
            if ($urandom % 3 == 0) begin reqF = 1'b1; addrF = $urandom; end
        end else begin
            if ($urandom % 16 == 0) addrF = $urandom;
            if ($urandom % 64 == 0) reqF = 1'b0;
        end
        if (ackM_d[0]) begin
            reqM   = 1'($urandom % 2);
            weM    = 1'($urandom % 2);
            addrM  = $urandom;
            wdataM = $urandom;
        end else if (!reqM) begin
            if ($urandom % 3 == 0) begin
                reqM = 1'b1; weM = 1'($urandom % 2); addrM = $urandom; wdataM = $urandom;
            end
        end else begin
            if ($urandom % 16 == 0) begin addrM = $urandom; wdataM = $urandom; end
            if ($urandom % 64 == 0) reqM = 1'b0;
        end
    endtask

    initial begin
        repeat (3) next_cycle();
        reset = 1'b0;
        repeat (2) next_cycle();

        // Single fetch read of 0x40.
        reqF = 1'b1; addrF = 32'h40;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("t1_stallcF", 0, stallcF_d[0], k < 3);
            chk("t1_mem_en", 0, mem_en_d[0], (k == 1) || (k == 2));
            chk("t1_ackF", 0, ackF_d[0], k == 3);
            chk("t1_lat1_ackF", 1, ackF_d[1], k == 2);
            if (k == 1) chk("t1_mem_addr", 0, mem_addr_d[0], 32'h40);
            if (k == 3) chk("t1_rdataF", 0, rdataF_d[0], 32'hA5A5A5E5);
            if (k < 3) next_cycle();
        end
        next_cycle();
        reqF = 1'b0;
        next_cycle();

        // Simultaneous F and M reads, M then re-requests: order M, F, M.
        reqF = 1'b1; addrF = 32'h80;
        reqM = 1'b1; weM = 1'b0; addrM = 32'h100;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) addrM = 32'h104;
            mid();
            if (k == 3) begin
                chk("t2_ackM_first", 0, ackM_d[0], 1);
                chk("t2_ackF_not_yet", 0, ackF_d[0], 0);
                chk("t2_rdataM", 0, rdataM_d[0], 32'hA5A5A4A5);
            end
            if (k == 6) begin
                chk("t2_ackF", 0, ackF_d[0], 1);
                chk("t2_rdataF", 0, rdataF_d[0], 32'hA5A5A525);
            end
            if (k == 9) begin
                chk("t2_ackM_second", 0, ackM_d[0], 1);
                chk("t2_rdataM2", 0, rdataM_d[0], 32'hA5A5A4A1);
                chk("t2_conflict", 0, conf0, 1);
            end
            next_cycle();
        end
        reqF = 1'b0; reqM = 1'b0;
        repeat (4) next_cycle();

        // Write leaves rdataM untouched.
        reqM = 1'b1; weM = 1'b1; addrM = 32'h8; wdataM = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            mid();
            if (k == 1) begin
                chk("t3_mem_we", 0, mem_we_d[0], 1);
                chk("t3_mem_wdata", 0, mem_wdata_d[0], 32'hDEADBEEF);
                chk("t3_mem_addr", 0, mem_addr_d[0], 32'h8);
            end
            if (k == 3) begin
                chk("t3_ackM", 0, ackM_d[0], 1);
                chk("t3_rdataM_kept", 0, rdataM_d[0], 32'hA5A5A4A1);
            end
            next_cycle();
        end
        reqM = 1'b0; weM = 1'b0;
        repeat (3) next_cycle();

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 1500; n++) begin
            drive_rand();
            if ($urandom % 250 == 0) begin
                #2 reset = 1'b1;
                next_cycle();
                reset = 1'b0;
            end else begin
                next_cycle();
            end
        end
        reqF = 1'b0; reqM = 1'b0;
        repeat (6) next_cycle();

        // Reset in the second access cycle of a fetch aborts it; held reqF is regranted.
        reqF = 1'b1; addrF = 32'h44;
        mid();
        next_cycle();
        mid();
        chk("t4_mem_en_c1", 0, mem_en_d[0], 1);
        next_cycle();
        #2 reset = 1'b1;
        mid();
        chk("t4_mem_en_rst", 0, mem_en_d[0], 0);
        next_cycle();
        reset = 1'b0;
        mid();
        chk("t4_no_ackF", 0, ackF_d[0], 0);
        repeat (3) next_cycle();
        mid();
        chk("t4_regrant_ackF", 0, ackF_d[0], 1);
        chk("t4_regrant_rdataF", 0, rdataF_d[0], 32'hA5A5A5E1);
        next_cycle();
        reqF = 1'b0;
        repeat (3) next_cycle();

        // Repeated simultaneous requests saturate the 4-bit counter.
        for (int r = 0; r < 20; r++) begin
            reqF = 1'b1; reqM = 1'b1; weM = 1'($urandom % 2);
            addrF = $urandom; addrM = $urandom; wdataM = $urandom;
            repeat (6) next_cycle();
            reqF = 1'b0; reqM = 1'b0;
            repeat (2) next_cycle();
        end
        repeat (4) next_cycle();
        mid();
        chk("t5_conflict_sat", 1, conf1, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
